// File: rtl/ring_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks.
package ring_meas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } meas_state_e;

   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int GATE_CYCLES_DEF = 1_000_000;
   localparam int GATE_CYCLES_SIM = 100;

endpackage

// File: rtl/ring_freq_counter_if.sv
// Control and result bundle between the frequency counter and its consumer.
interface ring_freq_counter_if #(
   parameter int CNT_W = ring_meas_pkg::CNT_W_DEF
);
   logic             enable;
   logic             clear_peak;
   logic [CNT_W-1:0] value_out;
   logic [CNT_W-1:0] peak_out;
   logic             sat_out;
   logic             valid;

   modport master (
      output enable, clear_peak,
      input  value_out, peak_out, sat_out, valid
   );

   modport slave (
      input  enable, clear_peak,
      output value_out, peak_out, sat_out, valid
   );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input with a one-cycle rising-edge pulse.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic fpga_clk1,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev;

   always_ff @(posedge fpga_clk1 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
         sync_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/ring_freq_counter.sv
// Gated edge counter for the ring oscillator: per-window count, running peak, saturation.
//
//   state | meaning
//   IDLE  | stopped; counters cleared, results held
//   ARM   | SYNC_STAGES+1 cycles flushing stale synchroniser contents
//   COUNT | counting rises in back-to-back GATE_CYCLES windows
module ring_freq_counter
   import ring_meas_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                fpga_clk1,
   input  logic                rst_n,
   input  logic                ring_in,
   ring_freq_counter_if.slave  meas
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam int AW = $clog2(SYNC_STAGES + 1);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [AW-1:0]    ARM_LAST  = AW'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   meas_state_e      state_q, state_d;
   logic [GW-1:0]    gate_q, gate_d;
   logic [AW-1:0]    arm_q, arm_d;
   logic [CNT_W-1:0] edge_q, edge_d;
   logic             win_sat_q, win_sat_d;
   logic [CNT_W-1:0] value_q, value_d;
   logic [CNT_W-1:0] peak_q, peak_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;
   logic             rise;
   logic [CNT_W-1:0] edge_next;
   logic             sat_next;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .fpga_clk1 (fpga_clk1),
      .rst_n     (rst_n),
      .async_in  (ring_in),
      .rise      (rise)
   );

   // Count including this cycle's rise; a blocked increment marks the window saturated.
   always_comb begin
      edge_next = edge_q;
      sat_next  = win_sat_q;
      if (edge_q == CNT_MAX) begin
         sat_next = win_sat_q | rise;
      end else begin
         edge_next = edge_q + CNT_W'(rise);
      end
   end

   always_comb begin
      state_d   = state_q;
      gate_d    = gate_q;
      arm_d     = arm_q;
      edge_d    = edge_q;
      win_sat_d = win_sat_q;
      value_d   = value_q;
      sat_d     = sat_q;
      peak_d    = peak_q;
      valid_d   = 1'b0;

      if (meas.clear_peak) peak_d = '0;

      case (state_q)
         IDLE: begin
            gate_d    = '0;
            edge_d    = '0;
            win_sat_d = 1'b0;
            arm_d     = ARM_LAST;
            if (meas.enable) state_d = ARM;
         end
         ARM: begin
            if (!meas.enable) begin
               state_d = IDLE;
            end else if (arm_q == '0) begin
               state_d = COUNT;
               gate_d  = GATE_LAST;
            end else begin
               arm_d = arm_q - AW'(1);
            end
         end
         COUNT: begin
            if (!meas.enable) begin
               state_d   = IDLE;
               gate_d    = '0;
               edge_d    = '0;
               win_sat_d = 1'b0;
            end else if (gate_q == '0) begin
               // Terminal cycle: publish and restart the next window without a gap.
               value_d   = edge_next;
               sat_d     = sat_next;
               valid_d   = 1'b1;
               if (meas.clear_peak || edge_next > peak_q) peak_d = edge_next;
               gate_d    = GATE_LAST;
               edge_d    = '0;
               win_sat_d = 1'b0;
            end else begin
               gate_d    = gate_q - GW'(1);
               edge_d    = edge_next;
               win_sat_d = sat_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge fpga_clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gate_q    <= '0;
         arm_q     <= '0;
         edge_q    <= '0;
         win_sat_q <= 1'b0;
         value_q   <= '0;
         peak_q    <= '0;
         sat_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gate_q    <= gate_d;
         arm_q     <= arm_d;
         edge_q    <= edge_d;
         win_sat_q <= win_sat_d;
         value_q   <= value_d;
         peak_q    <= peak_d;
         sat_q     <= sat_d;
         valid_q   <= valid_d;
      end
   end

   assign meas.value_out = value_q;
   assign meas.peak_out  = peak_q;
   assign meas.sat_out   = sat_q;
   assign meas.valid     = valid_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench for ring_freq_counter: latency, saturation, abort, peak handling, reset.
`timescale 1ns/1ps
module tb_ring_freq_counter;
   import ring_meas_pkg::*;

   localparam int GATE = GATE_CYCLES_SIM;

   logic fpga_clk1 = 1'b0;
   logic rst_n     = 1'b0;
   logic ring_in   = 1'b0;
   int   ring_half = 50;
   int   n_chk     = 0;
   int   n_pass    = 0;
   int   n;
   int   c;

   ring_freq_counter_if #(.CNT_W(16)) m16 ();
   ring_freq_counter_if #(.CNT_W(4))  m4 ();

   ring_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) dut16 (
      .fpga_clk1 (fpga_clk1),
      .rst_n     (rst_n),
      .ring_in   (ring_in),
      .meas      (m16.slave)
   );

   ring_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .fpga_clk1 (fpga_clk1),
      .rst_n     (rst_n),
      .ring_in   (ring_in),
      .meas      (m4.slave)
   );

   // Clock edges at 5 mod 10 ns, ring toggles at 0 mod 10 ns: no sampling races.
   always #5 fpga_clk1 = ~fpga_clk1;
   always begin
      #(ring_half);
      ring_in = ~ring_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge fpga_clk1);
      #1;
   endtask

   // n = clock edges waited until valid seen; max+1 on timeout.
   task automatic wait_valid(input bit use4, input int max, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!(use4 ? m4.valid : m16.valid) && cnt <= max);
   endtask

   task automatic count_valid(input bit use4, input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         tick();
         if (use4 ? m4.valid : m16.valid) cnt++;
      end
   endtask

   initial begin
      m16.enable = 1'b0; m16.clear_peak = 1'b0;
      m4.enable  = 1'b0; m4.clear_peak  = 1'b0;

      // 1: reset with ring toggling, then idle while enable low
      repeat (5) tick();
      chk("rst_value16", m16.value_out, 0);
      chk("rst_peak16",  m16.peak_out, 0);
      chk("rst_sat16",   m16.sat_out, 0);
      chk("rst_valid16", m16.valid, 0);
      chk("rst_value4",  m4.value_out, 0);
      rst_n = 1'b1;
      count_valid(0, 150, c);
      chk("idle_no_valid", c, 0);
      chk("idle_value", m16.value_out, 0);

      // 2: period 10 clk -> first valid at edge 103 (104th edge waited), then every 100
      m16.enable = 1'b1;
      wait_valid(0, 300, n);
      chk("first_latency", n, 104);
      chk("first_value", m16.value_out, 10);
      chk("first_sat", m16.sat_out, 0);
      chk("first_peak", m16.peak_out, 10);
      wait_valid(0, 300, n);
      chk("period", n, 100);
      chk("second_value", m16.value_out, 10);
      tick();
      chk("valid_one_cycle", m16.valid, 0);

      // 4: abort at gate_cnt 50, partial window discarded
      repeat (49) tick();
      m16.enable = 1'b0;
      count_valid(0, 200, c);
      chk("abort_no_valid", c, 0);
      chk("abort_value_held", m16.value_out, 10);
      m16.enable = 1'b1;
      wait_valid(0, 300, n);
      chk("reenable_latency", n, 104);
      chk("reenable_value", m16.value_out, 10);
      m16.enable = 1'b0;

      // 3: 4-bit counter saturates at period 2, recovers at period 10
      ring_half = 10;
      repeat (20) tick();
      m4.enable = 1'b1;
      wait_valid(1, 300, n);
      chk("sat_latency", n, 104);
      chk("sat_value", m4.value_out, 15);
      chk("sat_flag", m4.sat_out, 1);
      chk("sat_peak", m4.peak_out, 15);
      ring_half = 50;
      wait_valid(1, 300, n);
      chk("sat_period", n, 100);
      wait_valid(1, 300, n);
      chk("unsat_value", m4.value_out, 10);
      chk("unsat_flag", m4.sat_out, 0);
      chk("unsat_peak", m4.peak_out, 15);
      m4.enable = 1'b0;

      // 5: 5-edge windows against held peak 10, then peak clears
      ring_half = 100;
      repeat (20) tick();
      m16.enable = 1'b1;
      wait_valid(0, 300, n);
      chk("p5_latency", n, 104);
      chk("p5_value", m16.value_out, 5);
      chk("p5_peak_held", m16.peak_out, 10);
      repeat (99) tick();
      m16.clear_peak = 1'b1;
      tick();
      m16.clear_peak = 1'b0;
      chk("clr_term_valid", m16.valid, 1);
      chk("clr_term_value", m16.value_out, 5);
      chk("clr_term_peak", m16.peak_out, 5);
      repeat (30) tick();
      m16.clear_peak = 1'b1;
      tick();
      m16.clear_peak = 1'b0;
      chk("clr_mid_peak", m16.peak_out, 0);
      wait_valid(0, 300, n);
      chk("clr_mid_wait", n, 69);
      chk("clr_next_peak", m16.peak_out, 5);

      // 6: reset mid-window, then idle until enable
      repeat (40) tick();
      rst_n = 1'b0;
      m16.enable = 1'b0;
      #1;
      chk("midrst_value", m16.value_out, 0);
      chk("midrst_peak", m16.peak_out, 0);
      chk("midrst_sat", m16.sat_out, 0);
      chk("midrst_valid", m16.valid, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      count_valid(0, 200, c);
      chk("postrst_idle", c, 0);
      m16.enable = 1'b1;
      wait_valid(0, 300, n);
      chk("postrst_latency", n, 104);
      chk("postrst_value", m16.value_out, 5);
      chk("postrst_peak", m16.peak_out, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
